next_pc_unit: RTL and testbench

NEXT_PC_UNIT -- requirements
Module: next_pc_unit

---
 rtl/next_pc_unit.sv | 124 ++++++++++++
 tb/tb_next_pc_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/next_pc_unit.sv
// Next-PC selection with stall-tolerant redirect capture (IDLE/HOLD).
// Optional target alignment check: define NEXT_PC_ALIGN_CHECK_EN.
module next_pc_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCResult,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        JumpReg,
    input  logic [31:0] RegTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    output logic [31:0] Address,
    output logic        PCWrite,
    output logic        Flush,
    output logic        Pending,
    output logic [15:0] RedirectCount,
    output logic        MisalignErr
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] held_q, held_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    logic [31:0] pc_plus4;
    logic [31:0] live_tgt;
    logic [31:0] tgt;
    logic        live;
    logic        tgt_evt;
    logic        tgt_mis;

    function automatic logic [31:0] fix(input logic [31:0] t);
`ifdef NEXT_PC_ALIGN_CHECK_EN
        return {t[31:2], 2'b00};
`else
        return t;
`endif
    endfunction

    assign pc_plus4 = PCResult + 32'd4;
    assign live     = BranchTaken | JumpReg | Jump;
    assign live_tgt = BranchTaken ? BranchTarget :
                      JumpReg     ? RegTarget    : JumpTarget;

`ifdef NEXT_PC_ALIGN_CHECK_EN
    assign tgt_mis = |tgt[1:0];
`else
    assign tgt_mis = 1'b0;
`endif

    always_comb begin
        Address = pc_plus4;
        PCWrite = 1'b0;
        Flush   = 1'b0;
        state_d = state_q;
        held_d  = held_q;
        tgt     = live_tgt;
        tgt_evt = 1'b0;
        if (Reset) begin
            Address = 32'h0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!Stall) begin
                        PCWrite = 1'b1;
                        if (live) begin
                            Address = fix(live_tgt);
                            Flush   = 1'b1;
                            tgt_evt = 1'b1;
                        end
                    end else if (live) begin
                        state_d = HOLD;
                        held_d  = live_tgt;
                        tgt_evt = 1'b1;
                    end
                end
                HOLD: begin
                    // A newer resolved branch supersedes the held redirect
                    tgt     = BranchTaken ? BranchTarget : held_q;
                    Address = fix(tgt);
                    if (!Stall) begin
                        PCWrite = 1'b1;
                        Flush   = 1'b1;
                        state_d = IDLE;
                        tgt_evt = 1'b1;
                    end else if (BranchTaken) begin
                        held_d  = BranchTarget;
                        tgt_evt = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (PCWrite && Flush && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
        err_d = err_q | (tgt_evt & tgt_mis);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            held_q  <= 32'h0;
            cnt_q   <= 16'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign Pending       = (state_q == HOLD);
    assign RedirectCount = cnt_q;
    assign MisalignErr   = err_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Randomized bench for next_pc_unit against a redirect-queue model,
// plus hand-computed directed scenarios.
module tb_next_pc_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] PCResult = '0;
    logic        Stall = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic        JumpReg = 1'b0;
    logic [31:0] RegTarget = '0;
    logic        Jump = 1'b0;
    logic [31:0] JumpTarget = '0;
    logic [31:0] Address;
    logic        PCWrite;
    logic        Flush;
    logic        Pending;
    logic [15:0] RedirectCount;
    logic        MisalignErr;

    int total = 0;
    int bad = 0;

    next_pc_unit dut (
        .Clk(Clk), .Reset(Reset), .PCResult(PCResult), .Stall(Stall),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .JumpReg(JumpReg), .RegTarget(RegTarget),
        .Jump(Jump), .JumpTarget(JumpTarget),
        .Address(Address), .PCWrite(PCWrite), .Flush(Flush),
        .Pending(Pending), .RedirectCount(RedirectCount),
        .MisalignErr(MisalignErr)
    );

    always #5 Clk = ~Clk;

    // Model: an optional pending redirect, a count and a sticky error
    bit          m_hold = 0;
    logic [31:0] m_tgt = '0;
    int          m_cnt = 0;
    bit          m_err = 0;

    function automatic logic [31:0] fix(input logic [31:0] t);
`ifdef NEXT_PC_ALIGN_CHECK_EN
        return t & 32'hFFFF_FFFC;
`else
        return t;
`endif
    endfunction

    function automatic bit mis(input logic [31:0] t);
`ifdef NEXT_PC_ALIGN_CHECK_EN
        return t[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic predict(output logic [31:0] ea, output bit epcw,
                           output bit efl, output bit ea_ok,
                           output logic [31:0] et, output bit live,
                           output logic [31:0] r);
        live = BranchTaken || JumpReg || Jump;
        if (BranchTaken) r = BranchTarget;
        else if (JumpReg) r = RegTarget;
        else r = JumpTarget;
        epcw = !Stall;
        if (m_hold) begin
            et    = BranchTaken ? BranchTarget : m_tgt;
            efl   = !Stall;
            ea    = fix(et);
            ea_ok = !Stall;
        end else begin
            et    = r;
            efl   = !Stall && live;
            ea    = efl ? fix(r) : PCResult + 32'd4;
            ea_ok = !(Stall && live);
        end
    endtask

    always @(posedge Clk or posedge Reset) begin
        logic [31:0] ea, et, r;
        bit epcw, efl, ea_ok, live;
        if (Reset) begin
            m_hold = 0;
            m_tgt  = '0;
            m_cnt  = 0;
            m_err  = 0;
        end else begin
            predict(ea, epcw, efl, ea_ok, et, live, r);
            if (epcw && efl) begin
                if (m_cnt < 65535) m_cnt++;
                if (mis(et)) m_err = 1;
            end
            if (!m_hold && Stall && live) begin
                m_hold = 1;
                m_tgt  = r;
                if (mis(r)) m_err = 1;
            end else if (m_hold && Stall && BranchTaken) begin
                m_tgt = BranchTarget;
                if (mis(BranchTarget)) m_err = 1;
            end else if (m_hold && !Stall) begin
                m_hold = 0;
            end
        end
    end

    always @(negedge Clk) begin
        logic [31:0] ea, et, r;
        bit epcw, efl, ea_ok, live;
        if (Reset) begin
            chk("rst_addr", Address, 32'h0);
            chk("rst_pcw", {31'b0, PCWrite}, 32'h0);
            chk("rst_flush", {31'b0, Flush}, 32'h0);
            chk("rst_pend", {31'b0, Pending}, 32'h0);
            chk("rst_cnt", {16'b0, RedirectCount}, 32'h0);
        end else begin
            predict(ea, epcw, efl, ea_ok, et, live, r);
            if (ea_ok) chk("addr", Address, ea);
            chk("pcwrite", {31'b0, PCWrite}, {31'b0, epcw});
            chk("flush", {31'b0, Flush}, {31'b0, efl});
            chk("pending", {31'b0, Pending}, {31'b0, m_hold});
            chk("count", {16'b0, RedirectCount}, m_cnt);
            chk("misalign", {31'b0, MisalignErr}, {31'b0, m_err});
        end
    end

    task automatic setin(input bit st, input bit bt, input logic [31:0] btg,
                         input bit jr, input logic [31:0] rtg, input bit j,
                         input logic [31:0] jtg, input logic [31:0] pc);
        Stall = st; BranchTaken = bt; BranchTarget = btg;
        JumpReg = jr; RegTarget = rtg; Jump = j; JumpTarget = jtg;
        PCResult = pc;
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] rtgt();
        logic [31:0] v = $urandom;
        if ($urandom_range(0, 3) != 0) v = v & 32'hFFFF_FFFC;
        return v;
    endfunction

    initial begin
        setin(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        chk("d_rst_addr", Address, 32'h0);
        chk("d_rst_pend", {31'b0, Pending}, 32'h0);
        cyc();
        Reset = 0;

        setin(0, 0, 0, 0, 0, 0, 0, 32'h100);
        @(negedge Clk);
        chk("d_seq_addr", Address, 32'h104);
        chk("d_seq_pcw", {31'b0, PCWrite}, 32'h1);
        chk("d_seq_flush", {31'b0, Flush}, 32'h0);
        cyc();

        setin(0, 1, 32'h200, 1, 32'h400, 1, 32'h300, 32'h104);
        @(negedge Clk);
        chk("d_prio_addr", Address, 32'h200);
        chk("d_prio_flush", {31'b0, Flush}, 32'h1);
        cyc();

        setin(1, 0, 0, 0, 0, 1, 32'h300, 32'h200);
        @(negedge Clk);
        chk("d_cap_pcw", {31'b0, PCWrite}, 32'h0);
        chk("d_cap_cnt", {16'b0, RedirectCount}, 32'h1);
        cyc();
        for (int i = 0; i < 2; i++) begin
            setin(1, 0, 0, 0, 0, 0, 0, 32'h200);
            @(negedge Clk);
            chk("d_hold_pend", {31'b0, Pending}, 32'h1);
            chk("d_hold_pcw", {31'b0, PCWrite}, 32'h0);
            cyc();
        end
        setin(0, 0, 0, 0, 0, 0, 0, 32'h200);
        @(negedge Clk);
        chk("d_rel_addr", Address, 32'h300);
        chk("d_rel_flush", {31'b0, Flush}, 32'h1);
        chk("d_rel_pend", {31'b0, Pending}, 32'h1);
        cyc();
        setin(0, 0, 0, 0, 0, 0, 0, 32'h300);
        @(negedge Clk);
        chk("d_after_pend", {31'b0, Pending}, 32'h0);
        chk("d_after_cnt", {16'b0, RedirectCount}, 32'h2);
        cyc();

        setin(1, 0, 0, 0, 0, 1, 32'h300, 32'h304);
        cyc();
        setin(1, 0, 0, 0, 0, 0, 0, 32'h304);
        @(negedge Clk);
        chk("d_rh_pend", {31'b0, Pending}, 32'h1);
        #2 Reset = 1;
        #1;
        chk("d_rh_addr", Address, 32'h0);
        chk("d_rh_pend0", {31'b0, Pending}, 32'h0);
        chk("d_rh_cnt", {16'b0, RedirectCount}, 32'h0);
        #1 Reset = 0;
        cyc();
        setin(0, 0, 0, 0, 0, 0, 0, 32'h0);
        @(negedge Clk);
        chk("d_rh_next", Address, 32'h4);
        chk("d_rh_flush", {31'b0, Flush}, 32'h0);
        cyc();

        setin(0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
        @(negedge Clk);
        chk("d_wrap_addr", Address, 32'h0);
        chk("d_wrap_pcw", {31'b0, PCWrite}, 32'h1);
        cyc();

        setin(0, 0, 0, 0, 0, 1, 32'h302, 32'h0);
        @(negedge Clk);
`ifdef NEXT_PC_ALIGN_CHECK_EN
        chk("d_align_addr", Address, 32'h300);
`else
        chk("d_align_addr", Address, 32'h302);
`endif
        cyc();
        setin(0, 0, 0, 0, 0, 0, 0, 32'h300);
        @(negedge Clk);
`ifdef NEXT_PC_ALIGN_CHECK_EN
        chk("d_align_err", {31'b0, MisalignErr}, 32'h1);
`else
        chk("d_align_err", {31'b0, MisalignErr}, 32'h0);
`endif
        cyc();

        for (int i = 0; i < 3000; i++) begin
            Reset = ($urandom_range(0, 149) == 0);
            setin($urandom_range(0, 1) == 1,
                  $urandom_range(0, 4) == 0, rtgt(),
                  $urandom_range(0, 4) == 0, rtgt(),
                  $urandom_range(0, 3) == 0, rtgt(),
                  ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC
                                               : rtgt() & 32'hFFFF_FFFC);
            cyc();
        end
        Reset = 0;
        @(negedge Clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
